// File: rtl/xbar_pkg.sv
// Shared constants, lane type and parameter sanity check for the crossbar column family.
`ifndef XBOT
`define XBOT 4
`endif
`ifndef DATA
`define DATA 8
`endif

package xbar_pkg;
    localparam int XBAR_STRAIGHT  = 0;
    localparam int XBAR_UNSHUFFLE = 1;
    localparam int XBAR_SHUFFLE   = 2;

    localparam int XBAR_XREQ_DEF  = `XBOT;
    localparam int XBAR_XDATA_DEF = `DATA;

    typedef logic [XBAR_XDATA_DEF-1:0] lane_t;

    function automatic bit xbar_cfg_ok(input int n, input int shuffle);
        return (n >= 2) && ((n % 2) == 0) && (shuffle >= 0) && (shuffle <= 2);
    endfunction
endpackage

// File: rtl/xbar_column_pipe_if.sv
// Beat, config and status bundle of one crossbar column; slave = column side, master = driver side.
interface xbar_column_pipe_if #(
    parameter int XREQ_SIZE  = 4,
    parameter int XDATA_SIZE = 8,
    parameter int CNT_W      = 16
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  in_data;
    logic [XREQ_SIZE-1:0]                  in_lane_vld;
    logic                                  cfg_valid;
    logic [XREQ_SIZE/2-1:0]                cfg_sel;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  out_data;
    logic [XREQ_SIZE-1:0]                  out_lane_vld;
    logic [XREQ_SIZE/2-1:0]                active_sel;
    logic [CNT_W-1:0]                      beat_cnt;

    modport slave (
        input  in_valid, in_data, in_lane_vld, cfg_valid, cfg_sel, out_ready,
        output in_ready, out_valid, out_data, out_lane_vld, active_sel, beat_cnt
    );

    modport master (
        output in_valid, in_data, in_lane_vld, cfg_valid, cfg_sel, out_ready,
        input  in_ready, out_valid, out_data, out_lane_vld, active_sel, beat_cnt
    );
endinterface

// File: rtl/xbar_column_route.sv
// Combinational rank of 2x2 switches followed by straight / unshuffle / shuffle wiring.
// Zero latency, no state, no backpressure.
module xbar_column_route
    import xbar_pkg::*;
#(
    parameter int XREQ_SIZE = 4,
    parameter int LANE_W    = 9,
    parameter int SHUFFLE   = XBAR_UNSHUFFLE
) (
    input  logic [XREQ_SIZE-1:0][LANE_W-1:0] x_i,
    input  logic [XREQ_SIZE/2-1:0]           sel_i,
    output logic [XREQ_SIZE-1:0][LANE_W-1:0] o_o
);
    localparam int HALF = XREQ_SIZE / 2;

    logic [XREQ_SIZE-1:0][LANE_W-1:0] s;

    always_comb begin
        s = x_i;
        for (int k = 0; k < HALF; k++) begin
            s[2*k]   = sel_i[k] ? x_i[2*k+1] : x_i[2*k];
            s[2*k+1] = sel_i[k] ? x_i[2*k]   : x_i[2*k+1];
        end
    end

    always_comb begin
        o_o = s;
        for (int i = 0; i < HALF; i++) begin
            if (SHUFFLE == XBAR_UNSHUFFLE) begin
                o_o[i]      = s[2*i];
                o_o[i+HALF] = s[2*i+1];
            end else if (SHUFFLE == XBAR_SHUFFLE) begin
                o_o[2*i]    = s[i];
                o_o[2*i+1]  = s[i+HALF];
            end
        end
    end
endmodule

// File: rtl/xbar_column_pipe.sv
// Registered crossbar column with valid/ready; latency 1, or 2 behind an occupied skid (XBAR_COLUMN_SKID_EN).
// Backpressure: in_ready = !out_valid || out_ready, or a registered !skid_full with the skid enabled.
module xbar_column_pipe
    import xbar_pkg::*;
#(
    parameter int XREQ_SIZE  = XBAR_XREQ_DEF,
    parameter int XDATA_SIZE = $bits(lane_t),
    parameter int SHUFFLE    = XBAR_UNSHUFFLE,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    xbar_column_pipe_if.slave bus
);
    localparam int HALF = XREQ_SIZE / 2;
    localparam int LW   = XDATA_SIZE + 1;

    typedef logic [XREQ_SIZE-1:0][LW-1:0] beat_t;

    if (!xbar_cfg_ok(XREQ_SIZE, SHUFFLE)) begin : g_bad_cfg
        $error("xbar_column_pipe: XREQ_SIZE must be even and >= 2, SHUFFLE must be 0..2");
    end

    beat_t            in_beat, rt_beat, out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [HALF-1:0]  active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, xfer;

    // Occupancy bit rides as the top bit of each lane so it follows the data exactly.
    always_comb begin
        in_beat = '0;
        for (int i = 0; i < XREQ_SIZE; i++) begin
            in_beat[i] = {bus.in_lane_vld[i], bus.in_data[i]};
        end
    end

    xbar_column_route #(
        .XREQ_SIZE (XREQ_SIZE),
        .LANE_W    (LW),
        .SHUFFLE   (SHUFFLE)
    ) u_route (
        .x_i   (in_beat),
        .sel_i (active_q),
        .o_o   (rt_beat)
    );

    assign accept   = bus.in_valid && bus.in_ready;
    assign xfer     = out_vld_q && bus.out_ready;
    assign active_d = bus.cfg_valid ? bus.cfg_sel : active_q;
    assign cnt_d    = (xfer && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

`ifdef XBAR_COLUMN_SKID_EN
    beat_t [1:0] skid_q, skid_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [1:0]  fill_q, fill_d;
    logic        full_q;
    logic        out_free, push, pop;

    // Skid entries are already routed, so each beat keeps the setting in force when it was accepted.
    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        skid_d    = skid_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        fill_d    = fill_q;
        out_free  = !out_vld_q || bus.out_ready;
        pop       = out_free && (fill_q != 2'd0);
        push      = accept && !(out_free && (fill_q == 2'd0));
        if (pop) begin
            out_d     = skid_q[rd_q];
            out_vld_d = 1'b1;
            rd_d      = !rd_q;
        end else if (out_free) begin
            out_vld_d = accept;
            if (accept) out_d = rt_beat;
        end
        if (push) begin
            skid_d[wr_q] = rt_beat;
            wr_d         = !wr_q;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    assign bus.in_ready = reset_n && !full_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            skid_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            fill_q <= 2'd0;
            full_q <= 1'b0;
        end else begin
            skid_q <= skid_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fill_q <= fill_d;
            full_q <= (fill_d == 2'd2);
        end
    end
`else
    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (accept) begin
            out_d     = rt_beat;
            out_vld_d = 1'b1;
        end else if (xfer) begin
            out_vld_d = 1'b0;
        end
    end

    assign bus.in_ready = reset_n && (!out_vld_q || bus.out_ready);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            active_q  <= '0;
            cnt_q     <= '0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        bus.out_data     = '0;
        bus.out_lane_vld = '0;
        for (int i = 0; i < XREQ_SIZE; i++) begin
            bus.out_data[i]     = out_q[i][XDATA_SIZE-1:0];
            bus.out_lane_vld[i] = out_q[i][XDATA_SIZE];
        end
    end

    assign bus.out_valid  = out_vld_q;
    assign bus.active_sel = active_q;
    assign bus.beat_cnt   = cnt_q;
endmodule

// File: tb/tb_xbar_column_pipe.sv
// Bench for xbar_column_pipe: queue-based reference model plus directed literal checks.
module tb_xbar_column_pipe;
    localparam int NL = 4;
    localparam int W  = 8;

    typedef logic [NL-1:0][W-1:0] bus_t;
    typedef struct packed {
        bus_t          dat;
        logic [NL-1:0] vld;
    } mbeat_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    xbar_column_pipe_if #(.XREQ_SIZE(NL), .XDATA_SIZE(W), .CNT_W(4))  bus_a ();
    xbar_column_pipe_if #(.XREQ_SIZE(NL), .XDATA_SIZE(W), .CNT_W(16)) bus_b ();

    xbar_column_pipe #(.XREQ_SIZE(NL), .XDATA_SIZE(W), .SHUFFLE(1), .CNT_W(4)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    xbar_column_pipe #(.XREQ_SIZE(NL), .XDATA_SIZE(W), .SHUFFLE(2), .CNT_W(16)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     chk_en  = 0;
    mbeat_t mq[$];
    logic [1:0] m_sel;
    int     m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Forward map: where does each input lane land after the switch and the wiring.
    function automatic mbeat_t route_m(input int sh, input logic [1:0] sel, input bus_t d,
                                       input logic [NL-1:0] v);
        mbeat_t r;
        int p, o;
        r = '0;
        for (int j = 0; j < NL; j++) begin
            p = sel[j/2] ? (j ^ 1) : j;
            if (sh == 1)      o = (p % 2 == 0) ? p / 2 : p / 2 + NL / 2;
            else if (sh == 2) o = (p < NL / 2) ? 2 * p : 2 * (p - NL / 2) + 1;
            else              o = p;
            r.dat[o] = d[j];
            r.vld[o] = v[j];
        end
        return r;
    endfunction

    function automatic bit exp_rdy();
        if (!reset_n) return 1'b0;
`ifdef XBAR_COLUMN_SKID_EN
        return mq.size() < 3;
`else
        return (mq.size() == 0) || bus_a.out_ready;
`endif
    endfunction

    // Reference model for dut_a: a FIFO of routed beats; the head is what the output must show.
    initial forever begin
        @(posedge clock);
        begin
            bit     acc, xf;
            mbeat_t nb;
            if (!reset_n) begin
                mq.delete();
                m_sel = 2'b00;
                m_cnt = 0;
            end else begin
                acc = bus_a.in_valid && exp_rdy();
                xf  = (mq.size() > 0) && bus_a.out_ready;
                nb  = route_m(1, m_sel, bus_a.in_data, bus_a.in_lane_vld);
                if (xf) begin
                    void'(mq.pop_front());
                    if (m_cnt < 15) m_cnt++;
                end
                if (acc) mq.push_back(nb);
                if (bus_a.cfg_valid) m_sel = bus_a.cfg_sel;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("in_ready", bus_a.in_ready, exp_rdy());
            chk("out_valid", bus_a.out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_data", bus_a.out_data, mq[0].dat);
                chk("out_lane_vld", bus_a.out_lane_vld, mq[0].vld);
            end
            chk("active_sel", bus_a.active_sel, m_sel);
            chk("beat_cnt", bus_a.beat_cnt, m_cnt);
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
    endtask

    bus_t vx, vy;

    initial begin
        vx = {8'h33, 8'h22, 8'h11, 8'h00};
        vy = {8'h77, 8'h66, 8'h55, 8'h44};
        bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_lane_vld = '0;
        bus_a.cfg_valid = 0; bus_a.cfg_sel = '0; bus_a.out_ready = 1;
        bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_lane_vld = '0;
        bus_b.cfg_valid = 0; bus_b.cfg_sel = '0; bus_b.out_ready = 1;

        // reset state
        @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", bus_a.in_ready, 1'b0);
        nxt();
        reset_n = 1'b1;
        chk_en  = 1;
        @(negedge clock);
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_out_data", bus_a.out_data, 32'h0);
        chk("rst_out_lane_vld", bus_a.out_lane_vld, 4'h0);
        chk("rst_active_sel", bus_a.active_sel, 2'b00);
        chk("rst_beat_cnt", bus_a.beat_cnt, 4'd0);
        chk("rst_in_ready_rel", bus_a.in_ready, 1'b1);

        // config then one beat: unshuffle on dut_a, shuffle on dut_b
        nxt();
        bus_a.cfg_valid = 1; bus_a.cfg_sel = 2'b01;
        bus_b.cfg_valid = 1; bus_b.cfg_sel = 2'b10;
        nxt();
        bus_a.cfg_valid = 0; bus_a.in_valid = 1; bus_a.in_data = vx; bus_a.in_lane_vld = 4'b0100;
        bus_b.cfg_valid = 0; bus_b.in_valid = 1; bus_b.in_data = vx; bus_b.in_lane_vld = 4'b0100;
        nxt();
        bus_a.in_valid = 0;
        bus_b.in_valid = 0;
        @(negedge clock);
        chk("unshuf_valid", bus_a.out_valid, 1'b1);
        chk("unshuf_data", bus_a.out_data, 32'h33002211);
        chk("unshuf_lane_vld", bus_a.out_lane_vld, 4'b0010);
        chk("shuf_valid", bus_b.out_valid, 1'b1);
        chk("shuf_data", bus_b.out_data, 32'h22113300);
        chk("shuf_lane_vld", bus_b.out_lane_vld, 4'b1000);

        // stall for three cycles, then release
        nxt();
        do_reset();
        bus_a.out_ready = 0; bus_a.in_valid = 1; bus_a.in_data = vx; bus_a.in_lane_vld = 4'hF;
        nxt();
        bus_a.in_data = vy;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("stall_data", bus_a.out_data, 32'h33112200);
            chk("stall_valid", bus_a.out_valid, 1'b1);
            chk("stall_cnt", bus_a.beat_cnt, 4'd0);
`ifndef XBAR_COLUMN_SKID_EN
            chk("stall_in_ready", bus_a.in_ready, 1'b0);
`endif
            nxt();
        end
        bus_a.out_ready = 1;
`ifndef XBAR_COLUMN_SKID_EN
        @(negedge clock);
        chk("release_in_ready", bus_a.in_ready, 1'b1);
`endif
        nxt();
        bus_a.in_valid = 0;
        @(negedge clock);
        chk("release_cnt", bus_a.beat_cnt, 4'd1);
        chk("release_next_data", bus_a.out_data, 32'h77556644);

        // config in the same cycle as beat A, beat B one cycle later
        nxt();
        do_reset();
        bus_a.cfg_valid = 1; bus_a.cfg_sel = 2'b11; bus_a.in_valid = 1; bus_a.in_data = vx;
        nxt();
        bus_a.cfg_valid = 0;
        @(negedge clock);
        chk("cfg_old_data", bus_a.out_data, 32'h33112200);
        chk("cfg_active_sel", bus_a.active_sel, 2'b11);
        nxt();
        bus_a.in_valid = 0;
        @(negedge clock);
        chk("cfg_new_data", bus_a.out_data, 32'h22003311);

        // reset while a beat is stalled in the output register
        nxt();
        do_reset();
        bus_a.out_ready = 0; bus_a.in_valid = 1; bus_a.in_data = vx;
        bus_a.cfg_valid = 1; bus_a.cfg_sel = 2'b10;
        nxt();
        bus_a.in_valid = 0; bus_a.cfg_valid = 0;
        @(negedge clock);
        chk("pre_rst_valid", bus_a.out_valid, 1'b1);
        nxt();
        do_reset();
        bus_a.out_ready = 1;
        @(negedge clock);
        chk("midrst_valid", bus_a.out_valid, 1'b0);
        chk("midrst_sel", bus_a.active_sel, 2'b00);
        chk("midrst_cnt", bus_a.beat_cnt, 4'd0);
        chk("midrst_data", bus_a.out_data, 32'h0);
        repeat (3) nxt();
        @(negedge clock);
        chk("midrst_gone", bus_a.out_valid, 1'b0);
        chk("midrst_gone_cnt", bus_a.beat_cnt, 4'd0);

        // 20 back-to-back beats into a 4-bit counter
        nxt();
        do_reset();
        bus_a.out_ready = 1; bus_a.in_valid = 1;
        for (int b = 0; b < 20; b++) begin
            bus_a.in_data = $urandom;
            bus_a.in_lane_vld = 4'($urandom);
            nxt();
            @(negedge clock);
            chk("b2b_valid", bus_a.out_valid, 1'b1);
        end
        nxt();
        bus_a.in_valid = 0;
        @(negedge clock);
        chk("sat_cnt", bus_a.beat_cnt, 4'd15);
        repeat (3) nxt();
        @(negedge clock);
        chk("sat_hold", bus_a.beat_cnt, 4'd15);

        // randomized traffic, first segment with out_ready toggling every cycle
        nxt();
        for (int c = 0; c < 1500; c++) begin
            reset_n           = ($urandom_range(0, 299) != 0);
            bus_a.in_valid    = ($urandom_range(0, 3) != 0);
            bus_a.in_data     = {$urandom};
            bus_a.in_lane_vld = 4'($urandom);
            bus_a.cfg_valid   = ($urandom_range(0, 7) == 0);
            bus_a.cfg_sel     = 2'($urandom);
            bus_a.out_ready   = (c < 400) ? c[0] : ($urandom_range(0, 2) != 0);
            nxt();
        end
        reset_n = 1; bus_a.in_valid = 0; bus_a.cfg_valid = 0; bus_a.out_ready = 1;
        repeat (4) nxt();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
